// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared sizing constants and entry type for the store buffer
package store_buffer_pkg;
    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_PTR_W  = $clog2(SB_DEPTH);
    localparam int SB_CNT_W  = SB_PTR_W + 1;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core-side and memory-side signals of the store buffer
interface store_buffer_if #(
    parameter int DEPTH  = store_buffer_pkg::SB_DEPTH,
    parameter int ADDR_W = store_buffer_pkg::SB_ADDR_W,
    parameter int DATA_W = store_buffer_pkg::SB_DATA_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              cpu_mem_write;
    logic              cpu_mem_read;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              sb_empty;
    logic [CNT_W-1:0]  sb_count;

    // master is the core plus memory environment, slave is the buffer itself
    modport master (
        output cpu_mem_write, cpu_mem_read, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_write, mem_waddr, mem_wdata, mem_raddr,
               sb_empty, sb_count
    );

    modport slave (
        input  cpu_mem_write, cpu_mem_read, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        output cpu_rdata, cpu_stall, mem_write, mem_waddr, mem_wdata, mem_raddr,
               sb_empty, sb_count
    );
endinterface

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - youngest-matching-entry search for load forwarding
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  sb_entry_t                    entries_i [DEPTH],
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [$clog2(DEPTH)-1:0]     tail_i,
    input  logic [ADDR_W-3:0]            lookup_word_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            hit_data_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches overwrite earlier ones.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PTR_W'(k);
            if (valid_i[idx] && (entries_i[idx].addr[ADDR_W-1:2] == lookup_word_i)) begin
                hit_o      = 1'b1;
                hit_data_o = entries_i[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO between core data port and data memory
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t         entries_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid;
    logic              full, push, pop, hit;
    logic [DATA_W-1:0] hit_data;

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = bus.mem_write && bus.mem_ready;
    assign push = bus.cpu_mem_write && (!full || pop);

    assign bus.mem_write = (count_q != '0);
    assign bus.mem_waddr = entries_q[head_q].addr;
    assign bus.mem_wdata = entries_q[head_q].data;
    assign bus.mem_raddr = bus.cpu_addr;
    assign bus.cpu_stall = bus.cpu_mem_write && full && !pop;
    assign bus.sb_empty  = (count_q == '0);
    assign bus.sb_count  = count_q;
    assign bus.cpu_rdata = (bus.cpu_mem_read && hit) ? hit_data : bus.mem_rdata;

    // An entry is live when its distance from head is below the count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (CNT_W'(PTR_W'(i) - head_q) < count_q);
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: liveness comes solely from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail_q] <= '{addr: bus.cpu_addr, data: bus.cpu_wdata};
        end
    end

    sb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match (
        .entries_i     (entries_q),
        .valid_i       (valid),
        .tail_i        (tail_q),
        .lookup_word_i (bus.cpu_addr[ADDR_W-1:2]),
        .hit_o         (hit),
        .hit_data_o    (hit_data)
    );

    a_no_read_write: assert property (@(posedge clk) disable iff (rst)
        !(bus.cpu_mem_write && bus.cpu_mem_read));
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_rdata = bus.mem_raddr ^ 32'hDEAD_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    wr_t wlog[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (!rst && bus.mem_write && bus.mem_ready)
        wlog.push_back('{bus.mem_waddr, bus.mem_wdata, cyc});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        bus.cpu_mem_write = 1'b1;
        bus.cpu_addr      = a;
        bus.cpu_wdata     = d;
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wlog.size()) begin
            check({tag, "_addr"}, wlog[idx].a, a);
            check({tag, "_data"}, wlog[idx].d, d);
        end else begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int mcount;
        int pushed;
        bit done;
        bit w, r, pop_e, stall_e, psh;
        logic [31:0] ord_a [3];
        logic [31:0] ord_d [3];

        bus.cpu_mem_write = 1'b0;
        bus.cpu_mem_read  = 1'b0;
        bus.cpu_addr      = '0;
        bus.cpu_wdata     = '0;
        bus.mem_ready     = 1'b0;

        #3;
        check("rst_count", 32'(bus.sb_count), 32'd0);
        check("rst_empty", 32'(bus.sb_empty), 32'd1);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_stall", 32'(bus.cpu_stall), 32'd0);
        rst = 1'b0;
        tick();

        // three stores, then an asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h20 + 32'(4 * i), 32'h70 + 32'(i));
            tick();
        end
        bus.cpu_mem_write = 1'b0;
        #1;
        check("pre_rst_count", 32'(bus.sb_count), 32'd3);
        check("pre_rst_waddr", bus.mem_waddr, 32'h20);
        #1 rst = 1'b1;
        #1;
        check("async_rst_count", 32'(bus.sb_count), 32'd0);
        check("async_rst_empty", 32'(bus.sb_empty), 32'd1);
        check("async_rst_mem_write", 32'(bus.mem_write), 32'd0);
        rst = 1'b0;
        bus.cpu_mem_read = 1'b1;
        bus.cpu_addr     = 32'h10;
        #1;
        check("post_rst_load", bus.cpu_rdata, 32'hDEAD_0010);
        bus.cpu_mem_read = 1'b0;
        tick();

        // fill to DEPTH, stall the fifth store, then push-and-pop while full
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h100 + 32'(4 * i), 32'hA + 32'(i));
            #1;
            check("fill_no_stall", 32'(bus.cpu_stall), 32'd0);
            tick();
        end
        drive_store(32'h110, 32'hE);
        #1;
        check("full_count", 32'(bus.sb_count), 32'd4);
        check("full_stall", 32'(bus.cpu_stall), 32'd1);
        tick();
        check("held_count", 32'(bus.sb_count), 32'd4);
        check("held_stall", 32'(bus.cpu_stall), 32'd1);
        check("held_waddr", bus.mem_waddr, 32'h100);
        bus.mem_ready = 1'b1;
        #1;
        check("drain_unstall", 32'(bus.cpu_stall), 32'd0);
        check("drain_wdata", bus.mem_wdata, 32'hA);
        tick();
        bus.cpu_mem_write = 1'b0;
        bus.mem_ready     = 1'b0;
        #1;
        check("swap_count", 32'(bus.sb_count), 32'd4);
        check("swap_waddr", bus.mem_waddr, 32'h104);
        check("swap_wdata", bus.mem_wdata, 32'hB);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.mem_ready = 1'b0;
        check("full_drained_empty", 32'(bus.sb_empty), 32'd1);
        check("full_log_size", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check_log("full_log", i, 32'h100 + 32'(4 * i), 32'hA + 32'(i));

        // same-word stores forward the youngest
        drive_store(32'h200, 32'h11);
        tick();
        drive_store(32'h200, 32'h22);
        tick();
        bus.cpu_mem_write = 1'b0;
        bus.cpu_mem_read  = 1'b1;
        bus.cpu_addr      = 32'h200;
        #1 check("fwd_youngest", bus.cpu_rdata, 32'h22);
        bus.cpu_addr = 32'h202;
        #1 check("fwd_same_word", bus.cpu_rdata, 32'h22);
        bus.cpu_addr = 32'h204;
        #1 check("fwd_miss", bus.cpu_rdata, 32'hDEAD_0204);
        bus.cpu_mem_read = 1'b0;
        bus.cpu_addr     = 32'h200;
        #1 check("fwd_no_read", bus.cpu_rdata, 32'hDEAD_0200);
        bus.cpu_mem_read = 1'b1;
        bus.mem_ready    = 1'b1;
        tick();
        check("fwd_after_pop_count", 32'(bus.sb_count), 32'd1);
        check("fwd_after_pop", bus.cpu_rdata, 32'h22);
        tick();
        bus.cpu_mem_read = 1'b0;
        bus.mem_ready    = 1'b0;
        check("fwd_drained", 32'(bus.sb_empty), 32'd1);

        // back-to-back stores with memory always ready
        wlog.delete();
        bus.mem_ready = 1'b1;
        ord_a = '{32'h40, 32'h44, 32'h40};
        ord_d = '{32'h1, 32'h2, 32'h3};
        for (int i = 0; i < 3; i++) begin
            drive_store(ord_a[i], ord_d[i]);
            tick();
        end
        bus.cpu_mem_write = 1'b0;
        tick();
        tick();
        check("order_empty", 32'(bus.sb_empty), 32'd1);
        check("order_log_size", 32'(wlog.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_log("order_log", i, ord_a[i], ord_d[i]);
            if (i < wlog.size())
                check("order_consecutive", 32'(wlog[i].c - wlog[0].c), 32'(i));
        end

        // entry being popped still forwards
        bus.mem_ready = 1'b0;
        drive_store(32'h300, 32'h55);
        tick();
        bus.cpu_mem_write = 1'b0;
        bus.cpu_mem_read  = 1'b1;
        bus.cpu_addr      = 32'h300;
        bus.mem_ready     = 1'b1;
        #1 check("pop_cycle_fwd", bus.cpu_rdata, 32'h55);
        tick();
        check("after_pop_load", bus.cpu_rdata, 32'hDEAD_0300);
        check("after_pop_empty", 32'(bus.sb_empty), 32'd1);
        bus.cpu_mem_read = 1'b0;
        bus.mem_ready    = 1'b0;

        // pointer wrap under random drain back-pressure
        wlog.delete();
        mcount = 0;
        pushed = 0;
        done   = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (pushed == 10 && mcount == 0) begin
                done = 1'b1;
                break;
            end
            w = (pushed < 10) && ($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 1));
            bus.cpu_mem_write = w;
            bus.cpu_addr      = 32'h500 + 32'(4 * pushed);
            bus.cpu_wdata     = 32'h1000 + 32'(pushed);
            bus.mem_ready     = r;
            #1;
            pop_e   = (mcount != 0) && r;
            stall_e = w && (mcount == 4) && !pop_e;
            check("wrap_count", 32'(bus.sb_count), 32'(mcount));
            check("wrap_stall", 32'(bus.cpu_stall), 32'(stall_e));
            psh    = w && !stall_e;
            mcount = mcount + int'(psh) - int'(pop_e);
            if (psh) pushed++;
            tick();
        end
        bus.cpu_mem_write = 1'b0;
        bus.mem_ready     = 1'b0;
        if (!done) check("wrap_timeout", 32'd0, 32'd1);
        check("wrap_log_size", 32'(wlog.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            check_log("wrap_log", i, 32'h500 + 32'(4 * i), 32'h1000 + 32'(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
